// File: rtl/program_loader.sv
// Program memory write-side loader: assembles serial bytes (high byte first) into
// instruction words and issues one memory write per word until a halt word or a full memory.
module program_loader #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDRESS     = 11,
    parameter int N_INSTRUCTIONS = 16,
    parameter int NB_DATA        = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_DATA-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic                      o_wr_en,
    output logic [NB_ADDRESS-1:0]     o_wr_address,
    output logic [NB_INSTRUCTION-1:0] o_wr_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error
);

    localparam logic [NB_ADDRESS-1:0] LAST_ADDRESS = NB_ADDRESS'(N_INSTRUCTIONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        WRITE,
        DONE
    } state_t;

    state_t                  state;
    logic [NB_ADDRESS-1:0]   counter;
    logic [NB_DATA-1:0]      high_byte;
    logic [NB_DATA-1:0]      low_byte;
    logic                    is_halt;

    // The write address and data are the word counter and byte registers themselves.
    assign o_wr_address = counter;
    assign o_wr_data    = {high_byte, low_byte};
    assign is_halt      = (o_wr_data[NB_INSTRUCTION-1 -: 5] == 5'b00000);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            counter    <= '0;
            high_byte  <= '0;
            low_byte   <= '0;
            o_rx_ready <= 1'b0;
            o_wr_en    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state      <= HIGH;
                        counter    <= '0;
                        o_rx_ready <= 1'b1;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                        o_error    <= 1'b0;
                    end
                end
                HIGH: begin
                    if (i_rx_valid) begin
                        high_byte <= i_rx_data;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (i_rx_valid) begin
                        low_byte   <= i_rx_data;
                        o_rx_ready <= 1'b0;
                        o_wr_en    <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    o_wr_en <= 1'b0;
                    // A full memory without a halt word ends the load rather than wrapping.
                    if (is_halt || counter == LAST_ADDRESS) begin
                        state   <= DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_error <= !is_halt;
                    end else begin
                        counter    <= counter + 1'b1;
                        o_rx_ready <= 1'b1;
                        state      <= HIGH;
                    end
                end
                default: begin
                    state      <= IDLE;
                    o_rx_ready <= 1'b0;
                    o_wr_en    <= 1'b0;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads,
// compared every cycle against a transaction-level model of the byte stream.
module tb_program_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic        o_wr_en;
    logic [10:0] o_wr_address;
    logic [15:0] o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int vectors = 0;
    int miscompares = 0;

    // Model: a load is a byte stream; word k is {byte 2k, byte 2k+1}.
    bit          m_loading = 0;
    bit          m_wr = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    int          m_nbytes = 0;
    int          m_words = 0;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] m_word = 16'h0000;

    program_loader #(
        .NB_INSTRUCTION(16),
        .NB_ADDRESS    (11),
        .N_INSTRUCTIONS(16),
        .NB_DATA       (8)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_ready  (o_rx_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_address(o_wr_address),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkEq("rx_ready", 32'(o_rx_ready), 32'(m_loading && !m_wr));
        checkEq("busy",     32'(o_busy),     32'(m_loading));
        checkEq("wr_en",    32'(o_wr_en),    32'(m_wr));
        checkEq("done",     32'(o_done),     32'(m_done));
        checkEq("error",    32'(o_error),    32'(m_err));
        if (m_wr) begin
            checkEq("wr_address", 32'(o_wr_address), 32'(m_words));
            checkEq("wr_data",    32'(o_wr_data),    32'(m_word));
        end
    endtask

    // Advances the model across one rising edge given the inputs driven for it.
    task automatic modelEdge(input bit start, input bit valid, input logic [7:0] data);
        if (m_wr) begin
            m_wr = 0;
            if (m_word[15:11] == 5'b00000) begin
                m_loading = 0; m_done = 1; m_err = 0;
            end else if (m_words == 15) begin
                m_loading = 0; m_done = 1; m_err = 1;
            end else begin
                m_words++;
            end
        end else if (m_loading) begin
            if (valid) begin
                if (m_nbytes % 2 == 0) m_hi = data;
                else begin
                    m_word = {m_hi, data};
                    m_wr = 1;
                end
                m_nbytes++;
            end
        end else if (start) begin
            m_loading = 1; m_done = 0; m_err = 0; m_nbytes = 0; m_words = 0;
        end
    endtask

    task automatic applyStimulus(input bit start, input bit valid, input logic [7:0] data);
        @(negedge i_clk);
        checkOutput();
        i_start = start;
        i_rx_valid = valid;
        i_rx_data = data;
        modelEdge(start, valid, data);
    endtask

    // Sends one byte once the model expects the loader to be ready, with random idle gaps.
    task automatic sendByte(input logic [7:0] b, input int gapMax);
        while (m_wr) applyStimulus(1'b0, 1'b0, 8'($urandom));
        if (!m_loading) return;
        repeat ($urandom_range(0, gapMax)) applyStimulus(1'b0, 1'b0, 8'($urandom));
        applyStimulus(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        @(negedge i_clk);
        #2;
        i_reset = 1'b0;
        i_start = 1'b0;
        i_rx_valid = 1'b0;
        #1;
        checkEq("reset rx_ready",   32'(o_rx_ready),   32'd0);
        checkEq("reset wr_en",      32'(o_wr_en),      32'd0);
        checkEq("reset busy",       32'(o_busy),       32'd0);
        checkEq("reset done",       32'(o_done),       32'd0);
        checkEq("reset error",      32'(o_error),      32'd0);
        checkEq("reset wr_address", 32'(o_wr_address), 32'd0);
        checkEq("reset wr_data",    32'(o_wr_data),    32'd0);
        m_loading = 0; m_wr = 0; m_done = 0; m_err = 0; m_nbytes = 0; m_words = 0;
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    initial begin
        logic [7:0] hi;
        doReset();
        idle(2);

        // Three-word program ending in a halt word.
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h18, 0); sendByte(8'h05, 0);
        sendByte(8'h08, 0); sendByte(8'h00, 0);
        sendByte(8'h00, 0); sendByte(8'h00, 0);
        idle(3);

        // Sixteen non-halt words fill memory; later bytes are refused.
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            sendByte(8'h20, 0); sendByte(8'h00, 0);
        end
        idle(2);
        repeat (3) applyStimulus(1'b0, 1'b1, 8'hAB);

        // Restart from DONE with a byte offered in the start cycle, then toggling valid.
        applyStimulus(1'b1, 1'b1, 8'hAA);
        applyStimulus(1'b0, 1'b1, 8'h28);
        applyStimulus(1'b0, 1'b0, 8'h77);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h66);
        applyStimulus(1'b0, 1'b0, 8'h55);

        // Reset between the high and low byte discards the partial word.
        sendByte(8'h33, 0);
        doReset();
        idle(1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h00, 0); sendByte(8'h00, 0);
        idle(3);

        // Start pulsed while waiting for a low byte is ignored.
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h40, 0); sendByte(8'h01, 0);
        sendByte(8'h41, 0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h02, 1);
        sendByte(8'h00, 0); sendByte(8'h00, 0);
        idle(3);

        // Randomized loads with random gaps, halt words and occasional mid-load resets.
        for (int iter = 0; iter < 30; iter++) begin
            applyStimulus(1'b1, 1'b0, 8'($urandom));
            for (int w = 0; w < 20; w++) begin
                hi = 8'($urandom);
                if ($urandom_range(0, 7) == 0) hi[7:3] = 5'b00000;
                sendByte(hi, 2);
                if (!m_loading) break;
                if (iter % 7 == 3 && w == 2) begin
                    doReset();
                    break;
                end
                sendByte(8'($urandom), 2);
            end
            idle(3);
            repeat (2) applyStimulus(1'b0, 1'b1, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
